// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that lets several byte FIFOs share one UART transmitter.
// A grant is held for a burst of up to MaxBurst frames or until the granted FIFO runs dry.
module uart_tx_arbiter #(
  parameter int DataLength = 8,
  parameter int NumReq     = 4,
  parameter int MaxBurst   = 16
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic [NumReq*DataLength-1:0] i_req_data,
  input  logic [NumReq-1:0]            i_req_empty,
  output logic [NumReq-1:0]            o_req_read_en,
  input  logic [NumReq-1:0]            i_req_mask,
  output logic [DataLength-1:0]        o_tx_fifo_data,
  output logic                         o_tx_fifo_empty,
  input  logic                         i_tx_fifo_read_en,
  output logic [NumReq-1:0]            o_grant,
  output logic                         o_busy,
  output logic                         o_dbg_state
);

  localparam int IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;
  localparam logic [7:0] BurstLast = 8'(MaxBurst - 1);

  typedef enum logic {
    IDLE    = 1'b0,
    GRANTED = 1'b1
  } state_t;

  state_t            state;
  logic [IdxW-1:0]   grant_idx;
  logic [IdxW-1:0]   last_grant;
  logic [7:0]        burst_cnt;

  logic [NumReq-1:0] eligible;
  logic [IdxW-1:0]   winner;
  logic              any_eligible;
  int                cand;

  // Scan from farthest to nearest so the channel right after last_grant wins.
  always_comb begin
    eligible     = ~i_req_empty & i_req_mask;
    winner       = '0;
    any_eligible = 1'b0;
    cand         = 0;
    for (int i = NumReq; i >= 1; i--) begin
      cand = (int'(last_grant) + i) % NumReq;
      if (eligible[cand[IdxW-1:0]]) begin
        winner       = cand[IdxW-1:0];
        any_eligible = 1'b1;
      end
    end
  end

  // Data path is combinational from the granted channel; reset forces it idle at once.
  always_comb begin
    o_req_read_en   = '0;
    o_tx_fifo_data  = '0;
    o_tx_fifo_empty = 1'b1;
    if (state == GRANTED && !i_rst) begin
      o_tx_fifo_data           = i_req_data[int'(grant_idx)*DataLength +: DataLength];
      o_tx_fifo_empty          = i_req_empty[grant_idx];
      o_req_read_en[grant_idx] = i_tx_fifo_read_en;
    end
  end

  assign o_dbg_state = (state == GRANTED);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state      <= IDLE;
      grant_idx  <= '0;
      last_grant <= IdxW'(NumReq - 1);
      burst_cnt  <= '0;
      o_grant    <= '0;
      o_busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_eligible) begin
            state     <= GRANTED;
            grant_idx <= winner;
            burst_cnt <= '0;
            o_grant   <= NumReq'(1) << winner;
            o_busy    <= 1'b1;
          end
        end
        GRANTED: begin
          if (i_tx_fifo_read_en) begin
            if (burst_cnt == BurstLast) begin
              state      <= IDLE;
              last_grant <= grant_idx;
              o_grant    <= '0;
              o_busy     <= 1'b0;
            end else begin
              burst_cnt <= burst_cnt + 8'd1;
            end
          end else if (i_req_empty[grant_idx]) begin
            state      <= IDLE;
            last_grant <= grant_idx;
            o_grant    <= '0;
            o_busy     <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          o_grant <= '0;
          o_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: queue-backed requester FIFOs, a randomly pacing UART,
// and a burst-level round-robin model that predicts the (channel, byte) pop order.
module tb_uart_tx_arbiter;

  localparam int NUM = 4;
  localparam int DW  = 8;
  localparam int MB  = 4;
  localparam int IW  = 2;
  localparam int W   = IW + DW;

  logic                i_clk;
  logic                i_rst;
  logic [NUM*DW-1:0]   i_req_data;
  logic [NUM-1:0]      i_req_empty;
  logic [NUM-1:0]      o_req_read_en;
  logic [NUM-1:0]      i_req_mask;
  logic [DW-1:0]       o_tx_fifo_data;
  logic                o_tx_fifo_empty;
  logic                i_tx_fifo_read_en;
  logic [NUM-1:0]      o_grant;
  logic                o_busy;
  logic                o_dbg_state;

  logic [DW-1:0]       mem [NUM][256];
  int                  rd_ptr [NUM];
  int                  wr_ptr [NUM];
  logic [W-1:0]        exp_q[$];
  int                  n_checks = 0;
  int                  n_errors = 0;
  int                  m_last = NUM - 1;
  bit                  uart_on = 1'b0;

  uart_tx_arbiter #(.DataLength(DW), .NumReq(NUM), .MaxBurst(MB)) dut (
    .i_clk            (i_clk),
    .i_rst            (i_rst),
    .i_req_data       (i_req_data),
    .i_req_empty      (i_req_empty),
    .o_req_read_en    (o_req_read_en),
    .i_req_mask       (i_req_mask),
    .o_tx_fifo_data   (o_tx_fifo_data),
    .o_tx_fifo_empty  (o_tx_fifo_empty),
    .i_tx_fifo_read_en(i_tx_fifo_read_en),
    .o_grant          (o_grant),
    .o_busy           (o_busy),
    .o_dbg_state      (o_dbg_state)
  );

  // clock / reset
  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // first-word-fall-through requester FIFOs
  always_comb begin
    for (int k = 0; k < NUM; k++) begin
      i_req_empty[k]          = (rd_ptr[k] == wr_ptr[k]);
      i_req_data[k*DW +: DW]  = mem[k][8'(rd_ptr[k])];
    end
  end

  always @(posedge i_clk) begin
    for (int k = 0; k < NUM; k++)
      if (o_req_read_en[k]) rd_ptr[k] <= rd_ptr[k] + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic push(input int ch, input int n);
    for (int i = 0; i < n; i++) begin
      mem[ch][8'(wr_ptr[ch])] = DW'($urandom);
      wr_ptr[ch]++;
    end
  endtask

  task automatic expect_bytes(input int ch, input int n);
    for (int i = 0; i < n; i++)
      exp_q.push_back({IW'(ch), mem[ch][8'(rd_ptr[ch] + i)]});
  endtask

  task automatic check_pop();
    int ch = 0;
    logic [W-1:0] e;
    for (int k = 0; k < NUM; k++) if (o_req_read_en[k]) ch = k;
    check("pop_onehot", 32'($onehot(o_req_read_en)), 32'd1);
    check("pop_vs_grant", 32'(o_grant), 32'(o_req_read_en));
    check("pop_expected", 32'(exp_q.size() > 0), 32'd1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("pop_ch_data", 32'({ch[IW-1:0], o_tx_fifo_data}), 32'(e));
    end
  endtask

  task automatic step();
    @(negedge i_clk);
    i_tx_fifo_read_en = uart_on && !o_tx_fifo_empty && ($urandom_range(0, 2) == 0);
    #1;
    if (o_busy) check("grant_onehot", 32'($onehot(o_grant)), 32'd1);
    if (o_req_read_en != '0) check_pop();
  endtask

  task automatic run_until_idle(input int budget);
    int n = 0;
    uart_on = 1'b1;
    do begin
      step();
      n++;
    end while ((exp_q.size() != 0 || o_busy) && n < budget);
    uart_on = 1'b0;
    check("round_drained", exp_q.size(), 0);
    check("round_idle", 32'(o_busy), 0);
    exp_q.delete();
    step();
    check("stay_idle", 32'(o_grant), 0);
  endtask

  task automatic wait_grant(input logic [NUM-1:0] g, input int budget);
    int n = 0;
    do begin
      step();
      n++;
    end while (o_grant != g && n < budget);
    check("wait_grant", 32'(o_grant), 32'(g));
  endtask

  // Reference: whole bursts, round robin from the last owner, min(remaining, MB) bytes each.
  task automatic model_round(input logic [NUM-1:0] mask);
    int rem [NUM];
    int pos [NUM];
    int c;
    int win;
    for (int k = 0; k < NUM; k++) begin
      rem[k] = wr_ptr[k] - rd_ptr[k];
      pos[k] = rd_ptr[k];
    end
    forever begin
      win = -1;
      for (int i = 1; i <= NUM; i++) begin
        c = (m_last + i) % NUM;
        if (win < 0 && mask[c] && rem[c] > 0) win = c;
      end
      if (win < 0) break;
      for (int b = 0; b < MB && rem[win] > 0; b++) begin
        exp_q.push_back({IW'(win), mem[win][8'(pos[win])]});
        pos[win]++;
        rem[win]--;
      end
      m_last = win;
    end
  endtask

  initial begin
    int lvl;
    logic [NUM-1:0] mask;
    i_rst = 1'b1;
    i_req_mask = '1;
    i_tx_fifo_read_en = 1'b0;
    repeat (2) @(negedge i_clk);
    #1;
    check("rst_grant", 32'(o_grant), 0);
    check("rst_busy", 32'(o_busy), 0);
    check("rst_read_en", 32'(o_req_read_en), 0);
    check("rst_tx_empty", 32'(o_tx_fifo_empty), 1);
    check("rst_state", 32'(o_dbg_state), 0);
    i_tx_fifo_read_en = 1'b1;
    #1;
    check("rst_no_pop", 32'(o_req_read_en), 0);
    i_tx_fifo_read_en = 1'b0;
    @(negedge i_clk);
    i_rst = 1'b0;

    // round robin, twice so the second contention also starts at ch0
    for (int r = 0; r < 2; r++) begin
      push(0, 2);
      push(3, 2);
      model_round(4'b1111);
      run_until_idle(300);
    end

    // reset in the middle of a ch3 burst
    push(3, 4);
    expect_bytes(3, 1);
    uart_on = 1'b1;
    for (int n = 0; n < 100 && exp_q.size() != 0; n++) step();
    uart_on = 1'b0;
    check("rst_first_byte", exp_q.size(), 0);
    @(posedge i_clk);
    #1;
    i_tx_fifo_read_en = 1'b0;
    lvl = rd_ptr[3];
    @(negedge i_clk);
    i_tx_fifo_read_en = 1'b1;
    #1;
    check("pre_rst_fwd", 32'(o_req_read_en), 32'b1000);
    i_rst = 1'b1;
    #1;
    check("arst_grant", 32'(o_grant), 0);
    check("arst_busy", 32'(o_busy), 0);
    check("arst_read_en", 32'(o_req_read_en), 0);
    check("arst_tx_empty", 32'(o_tx_fifo_empty), 1);
    push(1, 2);
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    check("arst_no_fifo_pop", rd_ptr[3], lvl);
    i_tx_fifo_read_en = 1'b0;
    i_rst = 1'b0;
    m_last = NUM - 1;
    model_round(4'b1111);
    step();
    check("post_rst_first", 32'(o_grant), 32'b0010);
    run_until_idle(300);

    // single channel with grant latency
    @(negedge i_clk);
    push(2, 3);
    model_round(4'b1111);
    #1;
    check("grant_not_early", 32'(o_grant), 0);
    step();
    check("grant_latency", 32'(o_grant), 32'b0100);
    check("busy_on", 32'(o_busy), 1);
    check("state_granted", 32'(o_dbg_state), 1);
    run_until_idle(300);

    // burst limit
    push(1, 10);
    push(2, 1);
    model_round(4'b1111);
    run_until_idle(600);

    // stray pops while idle
    for (int i = 0; i < 3; i++) begin
      @(negedge i_clk);
      i_tx_fifo_read_en = 1'b1;
      #1;
      check("stray_no_pop", 32'(o_req_read_en), 0);
      check("stray_idle", 32'(o_busy), 0);
    end
    @(negedge i_clk);
    i_tx_fifo_read_en = 1'b0;

    // mask: only ch1 eligible, unmask ch0 while ch1 holds the grant
    i_req_mask = 4'b1110;
    push(0, 5);
    push(1, 1);
    wait_grant(4'b0010, 20);
    i_req_mask = 4'b1111;
    expect_bytes(1, 1);
    expect_bytes(0, 5);
    run_until_idle(400);
    m_last = 0;

    // masking the granted channel does not cut its burst
    push(2, 3);
    wait_grant(4'b0100, 20);
    i_req_mask = 4'b1011;
    expect_bytes(2, 3);
    run_until_idle(300);
    m_last = 2;
    i_req_mask = 4'b1111;

    // randomized rounds
    for (int r = 0; r < 12; r++) begin
      mask = NUM'($urandom_range(0, 15));
      i_req_mask = mask;
      for (int k = 0; k < NUM; k++) push(k, $urandom_range(0, 5));
      model_round(mask);
      run_until_idle(2000);
    end
    i_req_mask = '1;
    model_round(4'b1111);
    run_until_idle(2000);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
